// File: rtl/card_gfx_pkg.sv
// card_gfx_pkg: card geometry, palette, tile codes and records shared by the card renderer
package card_gfx_pkg;
   localparam int CARD_W = 32;
   localparam int CARD_H = 32;
   localparam int TILE_W = 5;
   localparam logic [7:0][11:0] PALETTE = {12'h0A0, 12'h888, 12'hFC0, 12'h00C,
                                          12'hD00, 12'h111, 12'hFFF, 12'h000};
   localparam logic [11:0] HILITE_RGB = 12'hFF0;
   typedef enum logic [TILE_W-1:0] {
      RANK_A = 5'd0, RANK_2, RANK_3, RANK_4, RANK_5, RANK_6, RANK_7,
      RANK_8, RANK_9, RANK_10, RANK_J, RANK_Q, RANK_K, CARD_BACK
   } tile_e;
   typedef struct packed {
      logic              valid;
      logic [9:0]        x;
      logic [9:0]        y;
      logic [TILE_W-1:0] tile;
   } card_slot_t;
   typedef struct packed {
      logic        hit;
      logic        hilite;
      logic        video;
      logic        hsync;
      logic        vsync;
      logic [11:0] bg;
   } pipe_t;
endpackage

// File: rtl/card_slot_table.sv
// card_slot_table: slot register file with highest-index-wins hit search against the current pixel
module card_slot_table
   import card_gfx_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int SLOT_W    = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_slot,
   input  logic [9:0]        wr_x,
   input  logic [9:0]        wr_y,
   input  logic [TILE_W-1:0] wr_tile,
   input  logic              wr_valid,
   input  logic              clear_all,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   output logic              hit,
   output logic [4:0]        dx,
   output logic [4:0]        dy,
   output logic [TILE_W-1:0] tile,
   output logic [SLOT_W-1:0] win_slot
);
   card_slot_t [NUM_SLOTS-1:0] slot_q, slot_d;
   logic [10:0] ddx, ddy;
   always_comb begin
      slot_d = slot_q;
      if (clear_all) for (int i = 0; i < NUM_SLOTS; i++) slot_d[i].valid = 1'b0;
      else if (wr_en) slot_d[wr_slot] = '{valid: wr_valid, x: wr_x, y: wr_y, tile: wr_tile};
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) slot_q <= '0;
      else slot_q <= slot_d;
   // A borrow makes the 11-bit difference >= 1024, so one compare also rejects pixels left/above the card
   always_comb begin
      hit = 1'b0;
      dx = '0;
      dy = '0;
      tile = '0;
      win_slot = '0;
      ddx = '0;
      ddy = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         ddx = {1'b0, pixel_x} - {1'b0, slot_q[i].x};
         ddy = {1'b0, pixel_y} - {1'b0, slot_q[i].y};
         if (slot_q[i].valid && ddx < 11'(CARD_W) && ddy < 11'(CARD_H)) begin
            hit = 1'b1;
            dx = ddx[4:0];
            dy = ddy[4:0];
            tile = slot_q[i].tile;
            win_slot = SLOT_W'(i);
         end
      end
   end
endmodule

// File: rtl/card_sprite_renderer.sv
// card_sprite_renderer: 3-stage card sprite pixel pipeline over the felt background (CARD_HILITE_EN adds slot outline)
module card_sprite_renderer
   import card_gfx_pkg::*;
#(
   parameter int NUM_SLOTS  = 8,
   parameter int SLOT_W     = 3,
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  video_on,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic [11:0]           bg_rgb,
   input  logic                  wr_en,
   input  logic [SLOT_W-1:0]     wr_slot,
   input  logic [9:0]            wr_x,
   input  logic [9:0]            wr_y,
   input  logic [4:0]            wr_tile,
   input  logic                  wr_valid,
   input  logic                  clear_all,
   input  logic [SLOT_W-1:0]     hilite_slot,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [11:0]           rgb,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic                  video_on_out
);
   logic              hit, hilite;
   logic [4:0]        dx, dy;
   logic [TILE_W-1:0] tile;
   logic [SLOT_W-1:0] win_slot;
   pipe_t             p1_d, p1_q, p2_d, p2_q;
   logic [ADDR_WIDTH-1:0] rom_addr_d, rom_addr_q;
   logic [11:0]       rgb_d, rgb_q;
   logic [2:0]        sync_d, sync_q;
   card_slot_table #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_table (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y),
      .wr_tile(wr_tile), .wr_valid(wr_valid), .clear_all(clear_all), .pixel_x(pixel_x),
      .pixel_y(pixel_y), .hit(hit), .dx(dx), .dy(dy), .tile(tile), .win_slot(win_slot)
   );
`ifdef CARD_HILITE_EN
   assign hilite = hit && win_slot == hilite_slot &&
                   (dx == 5'd0 || dx == 5'(CARD_W - 1) || dy == 5'd0 || dy == 5'(CARD_H - 1));
`else
   logic unused_hilite;
   assign hilite = 1'b0;
   assign unused_hilite = ^{hilite_slot, win_slot};
`endif
   // Transparent ROM texels reveal only the background, never a lower card
   always_comb begin
      p1_d = '{hit: hit, hilite: hilite, video: video_on, hsync: hsync_in, vsync: vsync_in, bg: bg_rgb};
      p2_d = p1_q;
      rom_addr_d = hit ? ADDR_WIDTH'({tile, dy, dx}) : '0;
      rgb_d = !p2_q.video ? 12'h000 :
              p2_q.hilite ? HILITE_RGB :
              (p2_q.hit && rom_data != '0) ? PALETTE[rom_data] : p2_q.bg;
      sync_d = {p2_q.video, p2_q.hsync, p2_q.vsync};
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         p1_q <= '0;
         p2_q <= '0;
         rom_addr_q <= '0;
         rgb_q <= '0;
         sync_q <= '0;
      end else begin
         p1_q <= p1_d;
         p2_q <= p2_d;
         rom_addr_q <= rom_addr_d;
         rgb_q <= rgb_d;
         sync_q <= sync_d;
      end
   assign rom_addr = rom_addr_q;
   assign rgb = rgb_q;
   assign {video_on_out, hsync_out, vsync_out} = sync_q;
endmodule

// File: tb/tb_card_sprite_renderer.sv
// tb_card_sprite_renderer: directed and randomized checks of the card renderer against a geometric reference model
module tb_card_sprite_renderer;
   import card_gfx_pkg::*;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
   logic [11:0] bg_rgb = '0;
   logic        wr_en = 1'b0, wr_valid = 1'b0, clear_all = 1'b0;
   logic [2:0]  wr_slot = '0, hilite_slot = 3'd7;
   logic [9:0]  wr_x = '0, wr_y = '0;
   logic [4:0]  wr_tile = '0;
   logic [14:0] rom_addr;
   logic [2:0]  rom_data;
   logic [11:0] rgb;
   logic        hsync_out, vsync_out, video_on_out;
   logic [2:0]  rom_mem [32768];
   int          m_x [8], m_y [8], m_tile [8];
   bit          m_valid [8];
   int          n_checks = 0, n_fail = 0;
   logic [14:0] e_addr [400];
   logic [11:0] e_rgb [400];
   logic [2:0]  e_sync [400];

   card_sprite_renderer dut (
      .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_rgb(bg_rgb), .wr_en(wr_en), .wr_slot(wr_slot),
      .wr_x(wr_x), .wr_y(wr_y), .wr_tile(wr_tile), .wr_valid(wr_valid), .clear_all(clear_all),
      .hilite_slot(hilite_slot), .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input int x, input int y, input bit vid, input logic [11:0] bg);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      video_on = vid;
      bg_rgb = bg;
   endtask

   task automatic write_slot(input int s, input int x, input int y, input int t, input bit v);
      wr_en = 1'b1;
      wr_slot = 3'(s);
      wr_x = 10'(x);
      wr_y = 10'(y);
      wr_tile = 5'(t);
      wr_valid = v;
      tick();
      wr_en = 1'b0;
      m_valid[s] = v;
      m_x[s] = x;
      m_y[s] = y;
      m_tile[s] = t;
   endtask

   task automatic clear_model();
      for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
   endtask

   function automatic void model(input int px, input int py, output bit h, output int addr, output bit hl);
      h = 1'b0;
      addr = 0;
      hl = 1'b0;
      for (int s = 7; s >= 0; s--) begin
         if (m_valid[s] && px >= m_x[s] && px < m_x[s] + 32 && py >= m_y[s] && py < m_y[s] + 32) begin
            int cx, cy;
            cx = px - m_x[s];
            cy = py - m_y[s];
            h = 1'b1;
            addr = m_tile[s] * 1024 + cy * 32 + cx;
`ifdef CARD_HILITE_EN
            hl = (s == int'(hilite_slot)) && (cx == 0 || cx == 31 || cy == 0 || cy == 31);
`endif
            return;
         end
      end
   endfunction

   function automatic logic [11:0] model_rgb(input int px, input int py, input bit vid, input logic [11:0] bg);
      bit h, hl;
      int a;
      model(px, py, h, a, hl);
      if (!vid) return 12'h000;
      if (hl) return HILITE_RGB;
      if (h && rom_mem[a] != 3'd0) return PALETTE[rom_mem[a]];
      return bg;
   endfunction

   task automatic test_reset();
      set_pix(0, 0, 1'b1, 12'hFFF);
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      tick();
      tick();
      n_checks++;
      if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", rom_addr); end
      n_checks++;
      if (rgb !== 12'h0) begin n_fail++; $display("FAIL reset_rgb got %h want 0", rgb); end
      n_checks++;
      if ({video_on_out, hsync_out, vsync_out} !== 3'b000) begin
         n_fail++; $display("FAIL reset_sync got %b want 000", {video_on_out, hsync_out, vsync_out});
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [11:0] bg = 12'h070;
      rom_mem[15'h0800] = 3'd3;
      write_slot(0, 100, 50, 2, 1'b1);
      hsync_in = 1'b1;
      vsync_in = 1'b0;
      set_pix(100, 50, 1'b1, bg);
      tick();
      n_checks++;
      if (rom_addr !== 15'h0800) begin n_fail++; $display("FAIL basic_addr got %h want 0800", rom_addr); end
      tick();
      tick();
      n_checks++;
      if (rgb !== PALETTE[3]) begin n_fail++; $display("FAIL basic_rgb got %h want %h", rgb, PALETTE[3]); end
      n_checks++;
      if ({video_on_out, hsync_out, vsync_out} !== 3'b110) begin
         n_fail++; $display("FAIL basic_sync got %b want 110", {video_on_out, hsync_out, vsync_out});
      end
      set_pix(131, 81, 1'b1, bg);
      tick();
      n_checks++;
      if (rom_addr !== 15'h0BFF) begin n_fail++; $display("FAIL corner_addr got %h want 0bff", rom_addr); end
      tick();
      tick();
      n_checks++;
      if (rgb !== model_rgb(131, 81, 1'b1, bg)) begin
         n_fail++; $display("FAIL corner_rgb got %h want %h", rgb, model_rgb(131, 81, 1'b1, bg));
      end
      set_pix(132, 50, 1'b1, bg);
      tick();
      n_checks++;
      if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL miss_addr got %h want 0", rom_addr); end
      tick();
      tick();
      n_checks++;
      if (rgb !== bg) begin n_fail++; $display("FAIL miss_rgb got %h want %h", rgb, bg); end
   endtask

   task automatic test_overlap();
      logic [11:0] bg = 12'h060;
      rom_mem[15'h3400] = 3'd0;
      rom_mem[2 * 1024 + 10 * 32 + 10] = 3'd5;
      write_slot(5, 110, 60, 13, 1'b1);
      set_pix(110, 60, 1'b1, bg);
      tick();
      n_checks++;
      if (rom_addr !== 15'h3400) begin n_fail++; $display("FAIL overlap_addr got %h want 3400", rom_addr); end
      tick();
      tick();
      n_checks++;
      if (rgb !== bg) begin n_fail++; $display("FAIL overlap_rgb got %h want %h", rgb, bg); end
   endtask

   task automatic test_wrap();
      logic [11:0] bg = 12'h050;
      logic [14:0] a = 15'(7 * 1024 + 10 * 32 + 13);
      rom_mem[a] = 3'd6;
      write_slot(2, 1010, 200, 7, 1'b1);
      set_pix(1023, 210, 1'b1, bg);
      tick();
      n_checks++;
      if (rom_addr !== a) begin n_fail++; $display("FAIL wrap_addr got %h want %h", rom_addr, a); end
      tick();
      tick();
      n_checks++;
      if (rgb !== PALETTE[6]) begin n_fail++; $display("FAIL wrap_rgb got %h want %h", rgb, PALETTE[6]); end
      set_pix(0, 210, 1'b1, bg);
      tick();
      n_checks++;
      if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL nowrap_addr got %h want 0", rom_addr); end
      tick();
      tick();
      n_checks++;
      if (rgb !== bg) begin n_fail++; $display("FAIL nowrap_rgb got %h want %h", rgb, bg); end
      set_pix(1023, 210, 1'b0, bg);
      tick();
      tick();
      tick();
      n_checks++;
      if (rgb !== 12'h0) begin n_fail++; $display("FAIL blank_rgb got %h want 0", rgb); end
      n_checks++;
      if (video_on_out !== 1'b0) begin n_fail++; $display("FAIL blank_video got %b want 0", video_on_out); end
   endtask

   task automatic test_hilite();
      logic [11:0] bg = 12'h040;
      logic [11:0] want;
      rom_mem[2 * 1024 + 10 * 32 + 0] = 3'd4;
      rom_mem[2 * 1024 + 10 * 32 + 1] = 3'd5;
      hilite_slot = 3'd0;
`ifdef CARD_HILITE_EN
      want = HILITE_RGB;
`else
      want = PALETTE[4];
`endif
      set_pix(100, 60, 1'b1, bg);
      tick();
      tick();
      tick();
      n_checks++;
      if (rgb !== want) begin n_fail++; $display("FAIL outline_rgb got %h want %h", rgb, want); end
      set_pix(101, 60, 1'b1, bg);
      tick();
      tick();
      tick();
      n_checks++;
      if (rgb !== PALETTE[5]) begin n_fail++; $display("FAIL inner_rgb got %h want %h", rgb, PALETTE[5]); end
      hilite_slot = 3'd7;
   endtask

   task automatic test_clear();
      logic [11:0] bg = 12'h030;
      wr_en = 1'b1;
      wr_slot = 3'd3;
      wr_x = 10'd300;
      wr_y = 10'd300;
      wr_tile = 5'd1;
      wr_valid = 1'b1;
      clear_all = 1'b1;
      tick();
      wr_en = 1'b0;
      clear_all = 1'b0;
      clear_model();
      set_pix(300, 300, 1'b1, bg);
      tick();
      n_checks++;
      if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL clear_new_addr got %h want 0", rom_addr); end
      set_pix(100, 50, 1'b1, bg);
      tick();
      n_checks++;
      if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL clear_old_addr got %h want 0", rom_addr); end
      tick();
      tick();
      n_checks++;
      if (rgb !== bg) begin n_fail++; $display("FAIL clear_rgb got %h want %h", rgb, bg); end
   endtask

   task automatic test_reset_mid();
      logic [11:0] bg = 12'h020;
      rom_mem[4 * 1024] = 3'd2;
      write_slot(1, 400, 100, 4, 1'b1);
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      set_pix(400, 100, 1'b1, bg);
      tick();
      tick();
      tick();
      n_checks++;
      if (rgb !== PALETTE[2]) begin n_fail++; $display("FAIL pre_reset_rgb got %h want %h", rgb, PALETTE[2]); end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (rgb !== 12'h0) begin n_fail++; $display("FAIL async_rgb got %h want 0", rgb); end
      n_checks++;
      if ({video_on_out, hsync_out, vsync_out} !== 3'b000) begin
         n_fail++; $display("FAIL async_sync got %b want 000", {video_on_out, hsync_out, vsync_out});
      end
      n_checks++;
      if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL async_addr got %h want 0", rom_addr); end
      clear_model();
      tick();
      reset_n = 1'b1;
      tick();
      n_checks++;
      if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL post_reset_addr got %h want 0", rom_addr); end
      tick();
      n_checks++;
      if (rgb !== 12'h0) begin n_fail++; $display("FAIL early_rgb got %h want 0", rgb); end
      tick();
      n_checks++;
      if (rgb !== bg) begin n_fail++; $display("FAIL first_rgb got %h want %h", rgb, bg); end
   endtask

   task automatic test_random();
      int n = 300;
      for (int r = 0; r < 3; r++) begin
         clear_all = 1'b1;
         tick();
         clear_all = 1'b0;
         clear_model();
         for (int s = 0; s < 8; s++)
            write_slot(s, $urandom_range(0, 1023), $urandom_range(0, 479), $urandom_range(0, 13),
                       ($urandom % 4) != 0);
         hilite_slot = 3'($urandom);
         for (int c = 0; c < n + 2; c++) begin
            int px, py, s, a;
            bit vid, h, hl;
            logic [11:0] bg;
            s = $urandom_range(0, 7);
            px = ($urandom % 8 == 0) ? $urandom_range(0, 1023) : ((m_x[s] + $urandom_range(0, 40) - 4) & 1023);
            py = ($urandom % 8 == 0) ? $urandom_range(0, 1023) : ((m_y[s] + $urandom_range(0, 40) - 4) & 1023);
            vid = (c < n) && ($urandom % 10 != 0);
            bg = 12'($urandom);
            set_pix(px, py, vid, bg);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            model(px, py, h, a, hl);
            e_addr[c] = 15'(a);
            e_rgb[c] = model_rgb(px, py, vid, bg);
            e_sync[c] = {vid, hsync_in, vsync_in};
            tick();
            n_checks++;
            if (rom_addr !== e_addr[c]) begin
               n_fail++; $display("FAIL rand_addr c=%0d got %h want %h", c, rom_addr, e_addr[c]);
            end
            if (c >= 2) begin
               n_checks++;
               if (rgb !== e_rgb[c-2]) begin
                  n_fail++; $display("FAIL rand_rgb c=%0d got %h want %h", c, rgb, e_rgb[c-2]);
               end
               n_checks++;
               if ({video_on_out, hsync_out, vsync_out} !== e_sync[c-2]) begin
                  n_fail++;
                  $display("FAIL rand_sync c=%0d got %b want %b", c, {video_on_out, hsync_out, vsync_out}, e_sync[c-2]);
               end
            end
         end
      end
      hilite_slot = 3'd7;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) rom_mem[i] = 3'($urandom);
      clear_model();
      test_reset();
      test_basic();
      test_overlap();
      test_wrap();
      test_hilite();
      test_clear();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
